// File: rtl/fpsqrt_pkg.sv
// Shared encodings and the request record for the fpsqrt request queue.
// The tag field width is the package default; the queue is built around it.
package fpsqrt_pkg;

    localparam logic [1:0] FP_FMT_FP16 = 2'd0;
    localparam logic [1:0] FP_FMT_FP32 = 2'd1;
    localparam logic [1:0] FP_FMT_FP64 = 2'd2;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int unsigned TAG_W_DEFAULT = 4;

    typedef struct packed {
        logic [1:0]               fp_format;
        logic [63:0]              op;
        logic [2:0]               rm;
        logic                     vector_mode;
        logic [TAG_W_DEFAULT-1:0] tag;
    } fpsqrt_req_t;

    typedef enum logic [0:0] {StIdle, StBusy} issue_state_e;

endpackage

// File: rtl/fpsqrt_req_queue_if.sv
// Request, sqrt start/finish and response handshakes of the fpsqrt request queue.
// The queue binds to the slave modport; its environment drives the master side.
interface fpsqrt_req_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_fp_format_i;
    logic [63:0]      req_op_i;
    logic [2:0]       req_rm_i;
    logic             req_vector_mode_i;
    logic [TAG_W-1:0] req_tag_i;

    logic             sqrt_start_valid_o;
    logic             sqrt_start_ready_i;
    logic [1:0]       sqrt_fp_format_o;
    logic [63:0]      sqrt_op_o;
    logic [2:0]       sqrt_rm_o;
    logic             sqrt_vector_mode_o;
    logic             sqrt_flush_o;
    logic             sqrt_finish_valid_i;
    logic             sqrt_finish_ready_o;
    logic [63:0]      sqrt_res_i;
    logic [4:0]       sqrt_fflags_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [63:0]      rsp_res_o;
    logic [4:0]       rsp_fflags_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [CNT_W-1:0] count_o;

    modport slave (
        input  flush_i, req_valid_i, req_fp_format_i, req_op_i, req_rm_i, req_vector_mode_i,
               req_tag_i, sqrt_start_ready_i, sqrt_finish_valid_i, sqrt_res_i, sqrt_fflags_i,
               rsp_ready_i,
        output req_ready_o, sqrt_start_valid_o, sqrt_fp_format_o, sqrt_op_o, sqrt_rm_o,
               sqrt_vector_mode_o, sqrt_flush_o, sqrt_finish_ready_o, rsp_valid_o, rsp_res_o,
               rsp_fflags_o, rsp_tag_o, count_o
    );

    modport master (
        output flush_i, req_valid_i, req_fp_format_i, req_op_i, req_rm_i, req_vector_mode_i,
               req_tag_i, sqrt_start_ready_i, sqrt_finish_valid_i, sqrt_res_i, sqrt_fflags_i,
               rsp_ready_i,
        input  req_ready_o, sqrt_start_valid_o, sqrt_fp_format_o, sqrt_op_o, sqrt_rm_o,
               sqrt_vector_mode_o, sqrt_flush_o, sqrt_finish_ready_o, rsp_valid_o, rsp_res_o,
               rsp_fflags_o, rsp_tag_o, count_o
    );

endinterface

// File: rtl/fpsqrt_req_fifo.sv
// Power-of-two circular request buffer with occupancy count and synchronous flush.
// Storage is deliberately left unreset; only pointers and count are cleared.
module fpsqrt_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer width equals log2(DEPTH), so increments wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fpsqrt_req_queue.sv
// Queues tagged sqrt requests, issues them one at a time to the sqrt unit and
// returns each result with its original tag through a registered response slot.
module fpsqrt_req_queue
    import fpsqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    fpsqrt_req_queue_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fpsqrt_req_t      wr_req, head, issue_req;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;
    logic             busy, start_valid, start_hs, finish_ready, finish_hs, capture;

    issue_state_e     state_q, state_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] inflight_tag_q, rsp_tag_q;
    logic [63:0]      rsp_res_q;
    logic [4:0]       rsp_fflags_q;

    always_comb begin
        wr_req             = '0;
        wr_req.fp_format   = bus.req_fp_format_i;
        wr_req.op          = bus.req_op_i;
        wr_req.rm          = bus.req_rm_i;
        wr_req.vector_mode = bus.req_vector_mode_i;
        wr_req.tag         = bus.req_tag_i;
    end

    assign bus.req_ready_o = ~full & ~bus.flush_i;
    assign push            = bus.req_valid_i & bus.req_ready_o;

    fpsqrt_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpsqrt_req_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush_i),
        .push  (push),
        .wdata (wr_req),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign busy         = (state_q == StBusy);
    assign start_valid  = ~busy & ~empty;
    assign start_hs     = start_valid & bus.sqrt_start_ready_i;
    assign pop          = start_hs & ~bus.flush_i;
    assign finish_ready = ~busy | ~rsp_valid_q | bus.rsp_ready_i;
    assign finish_hs    = bus.sqrt_finish_valid_i & finish_ready;
    // A finish seen while idle is a stale result from a flushed op: accept and drop it.
    assign capture      = busy & finish_hs & ~bus.flush_i;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle:  if (start_hs)  state_d = StBusy;
            StBusy:  if (finish_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rsp_valid_q && bus.rsp_ready_i) rsp_valid_d = 1'b0;
        if (capture)                        rsp_valid_d = 1'b1;
        if (bus.flush_i) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rsp_valid_q    <= 1'b0;
            inflight_tag_q <= '0;
            rsp_res_q      <= '0;
            rsp_fflags_q   <= '0;
            rsp_tag_q      <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            if (pop) inflight_tag_q <= head.tag;
            if (capture) begin
                rsp_res_q    <= bus.sqrt_res_i;
                rsp_fflags_q <= bus.sqrt_fflags_i;
                rsp_tag_q    <= inflight_tag_q;
            end
        end
    end

    assign issue_req = start_valid ? head : '0;

    assign bus.sqrt_start_valid_o  = start_valid;
    assign bus.sqrt_fp_format_o    = issue_req.fp_format;
    assign bus.sqrt_op_o           = issue_req.op;
    assign bus.sqrt_rm_o           = issue_req.rm;
    assign bus.sqrt_vector_mode_o  = issue_req.vector_mode;
    assign bus.sqrt_flush_o        = bus.flush_i;
    assign bus.sqrt_finish_ready_o = finish_ready;
    assign bus.rsp_valid_o         = rsp_valid_q;
    assign bus.rsp_res_o           = rsp_res_q;
    assign bus.rsp_fflags_o        = rsp_fflags_q;
    assign bus.rsp_tag_o           = rsp_tag_q;
    assign bus.count_o             = count;

endmodule

// File: tb/tb_fpsqrt_req_queue.sv
// Directed and randomized checks of fpsqrt_req_queue against a small sqrt-unit
// model and an in-order response scoreboard.
module tb_fpsqrt_req_queue;
    import fpsqrt_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    fpsqrt_req_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    fpsqrt_req_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_res(input logic [63:0] op);
        return {op[31:0], op[63:32]} ^ 64'h5A5A_0F0F_3C3C_9669;
    endfunction

    function automatic logic [4:0] model_flags(input logic [63:0] op);
        return op[4:0] ^ 5'h15;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input logic [3:0] tag, input logic [63:0] op, input logic [1:0] fmt,
                            input logic [2:0] rm);
        bus.req_valid_i       = 1'b1;
        bus.req_tag_i         = tag;
        bus.req_op_i          = op;
        bus.req_fp_format_i   = fmt;
        bus.req_rm_i          = rm;
        bus.req_vector_mode_i = 1'b0;
        tick();
        bus.req_valid_i       = 1'b0;
    endtask

    // Start the head op, then deliver its finish on the following cycle.
    task automatic issue_one(input logic [63:0] res, input logic [4:0] ff);
        bus.sqrt_start_ready_i  = 1'b1;
        tick();
        bus.sqrt_start_ready_i  = 1'b0;
        bus.sqrt_finish_valid_i = 1'b1;
        bus.sqrt_res_i          = res;
        bus.sqrt_fflags_i       = ff;
        tick();
        bus.sqrt_finish_valid_i = 1'b0;
    endtask

    logic [1:0]  fmts [5];
    logic [2:0]  rms  [5];
    logic [63:0] ops  [5];
    logic [72:0] exp_q [$];
    logic [72:0] e;
    int unsigned pushed, got, cyc;
    int unsigned m_cnt;
    logic        m_busy, req_hs, start_hs, fin_hs, rsp_hs;
    logic [63:0] m_op;

    initial begin
        bus.flush_i = 0; bus.req_valid_i = 0; bus.req_fp_format_i = 0; bus.req_op_i = 0;
        bus.req_rm_i = 0; bus.req_vector_mode_i = 0; bus.req_tag_i = 0;
        bus.sqrt_start_ready_i = 0; bus.sqrt_finish_valid_i = 0; bus.sqrt_res_i = 0;
        bus.sqrt_fflags_i = 0; bus.rsp_ready_i = 0;
        fmts = '{FP_FMT_FP16, FP_FMT_FP32, FP_FMT_FP64, FP_FMT_FP32, FP_FMT_FP16};
        rms  = '{RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM};
        for (int i = 0; i < 5; i++) ops[i] = 64'h3FF0_0000_0000_0000 + 64'(i * 17);

        // Reset values
        #3;
        chk("reset_outs", {bus.sqrt_start_valid_o, bus.rsp_valid_o, bus.count_o,
                           bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o, bus.sqrt_op_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset_ready", bus.req_ready_o, 1'b1);

        // Single request: sqrt(4.0)
        bus.req_valid_i = 1; bus.req_op_i = 64'h4080_0000; bus.req_fp_format_i = FP_FMT_FP32;
        bus.req_rm_i = RM_RNE; bus.req_tag_i = 4'd3;
        #1;
        chk("single_pre", {bus.req_ready_o, bus.sqrt_start_valid_o}, 2'b10);
        tick();
        bus.req_valid_i = 0;
        chk("single_head", {bus.count_o, bus.sqrt_start_valid_o, bus.sqrt_fp_format_o,
                            bus.sqrt_op_o}, {3'd1, 1'b1, FP_FMT_FP32, 64'h4080_0000});
        bus.sqrt_start_ready_i = 1;
        tick();
        bus.sqrt_start_ready_i = 0;
        chk("single_busy", {bus.count_o, bus.sqrt_start_valid_o, bus.sqrt_op_o}, '0);
        repeat (9) tick();
        bus.sqrt_finish_valid_i = 1; bus.sqrt_res_i = 64'h4000_0000; bus.sqrt_fflags_i = 0;
        #1;
        chk("single_fin_rdy", bus.sqrt_finish_ready_o, 1'b1);
        tick();
        bus.sqrt_finish_valid_i = 0;
        chk("single_rsp", {bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o},
            {1'b1, 64'h4000_0000, 5'd0, 4'd3});
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;
        chk("single_drain", {bus.rsp_valid_o, bus.rsp_res_o}, {1'b0, 64'h4000_0000});

        // Fill to full with the start side stalled
        for (int i = 0; i < 5; i++) begin
            bus.req_valid_i = 1; bus.req_tag_i = 4'(i); bus.req_op_i = ops[i];
            bus.req_fp_format_i = fmts[i]; bus.req_rm_i = rms[i]; bus.req_vector_mode_i = 1'(i);
            #1;
            chk("fill_ready", bus.req_ready_o, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        bus.req_valid_i = 0;
        #1;
        chk("fill_full", {bus.count_o, bus.req_ready_o}, {3'd4, 1'b0});
        bus.rsp_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_head", {bus.sqrt_start_valid_o, bus.sqrt_fp_format_o, bus.sqrt_op_o,
                              bus.sqrt_rm_o, bus.sqrt_vector_mode_o},
                {1'b1, fmts[i], ops[i], rms[i], 1'(i)});
            issue_one(model_res(ops[i]), model_flags(ops[i]));
            chk("fill_rsp", {bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o},
                {1'b1, model_res(ops[i]), model_flags(ops[i]), 4'(i)});
            chk("fill_b2b", bus.sqrt_start_valid_o, (i < 3) ? 1'b1 : 1'b0);
        end
        tick();
        chk("fill_empty", {bus.rsp_valid_o, bus.count_o}, '0);
        bus.rsp_ready_i = 0;

        // Response backpressure
        push_one(4'd5, 64'hA, FP_FMT_FP64, RM_RTZ);
        push_one(4'd6, 64'hB, FP_FMT_FP64, RM_RTZ);
        issue_one(64'h1111_1111_1111_1111, 5'h01);
        bus.sqrt_start_ready_i = 1;
        tick();
        bus.sqrt_start_ready_i = 0;
        bus.sqrt_finish_valid_i = 1; bus.sqrt_res_i = 64'h2222_2222_2222_2222;
        bus.sqrt_fflags_i = 5'h02;
        #1;
        chk("bp_fin_rdy_lo", bus.sqrt_finish_ready_o, 1'b0);
        repeat (2) begin
            tick();
            chk("bp_hold", {bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o},
                {1'b1, 64'h1111_1111_1111_1111, 5'h01, 4'd5});
        end
        bus.rsp_ready_i = 1;
        #1;
        chk("bp_fin_rdy_hi", bus.sqrt_finish_ready_o, 1'b1);
        tick();
        bus.sqrt_finish_valid_i = 0;
        chk("bp_replace", {bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o},
            {1'b1, 64'h2222_2222_2222_2222, 5'h02, 4'd6});
        tick();
        chk("bp_drain", bus.rsp_valid_o, 1'b0);
        bus.rsp_ready_i = 0;

        // Flush with a held response, 3 queued and 1 in flight
        push_one(4'd7, 64'hC, FP_FMT_FP16, RM_RUP);
        issue_one(64'h3333, 5'h03);
        for (int i = 8; i < 12; i++) push_one(4'(i), 64'(i), FP_FMT_FP32, RM_RMM);
        bus.sqrt_start_ready_i = 1;
        tick();
        bus.sqrt_start_ready_i = 0;
        chk("flush_pre", {bus.count_o, bus.rsp_valid_o}, {3'd3, 1'b1});
        bus.flush_i = 1;
        #1;
        chk("flush_fanout", {bus.sqrt_flush_o, bus.req_ready_o}, 2'b10);
        tick();
        bus.flush_i = 0;
        #1;
        chk("flush_after", {bus.count_o, bus.rsp_valid_o, bus.sqrt_start_valid_o,
                            bus.sqrt_flush_o}, '0);
        bus.sqrt_finish_valid_i = 1; bus.sqrt_res_i = 64'h4444;
        #1;
        chk("stale_rdy", bus.sqrt_finish_ready_o, 1'b1);
        tick();
        bus.sqrt_finish_valid_i = 0;
        chk("stale_drop", bus.rsp_valid_o, 1'b0);
        push_one(4'd12, 64'hD, FP_FMT_FP32, RM_RNE);
        chk("flush_idle", bus.sqrt_start_valid_o, 1'b1);
        issue_one(model_res(64'hD), model_flags(64'hD));
        chk("flush_next_rsp", {bus.rsp_valid_o, bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o},
            {1'b1, model_res(64'hD), model_flags(64'hD), 4'd12});
        bus.rsp_ready_i = 1;
        tick();
        bus.rsp_ready_i = 0;

        // Asynchronous reset while busy with a held response
        push_one(4'd1, 64'hE, FP_FMT_FP64, RM_RDN);
        issue_one(64'h5555, 5'h05);
        push_one(4'd2, 64'hF, FP_FMT_FP64, RM_RDN);
        push_one(4'd3, 64'h10, FP_FMT_FP64, RM_RDN);
        bus.sqrt_start_ready_i = 1;
        tick();
        bus.sqrt_start_ready_i = 0;
        chk("rst_pre", {bus.rsp_valid_o, bus.count_o}, {1'b1, 3'd1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {bus.sqrt_start_valid_o, bus.rsp_valid_o, bus.count_o, bus.rsp_res_o,
                          bus.rsp_fflags_o, bus.rsp_tag_o, bus.sqrt_op_o}, '0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", bus.req_ready_o, 1'b1);
        bus.sqrt_finish_valid_i = 1;
        tick();
        bus.sqrt_finish_valid_i = 0;
        chk("rst_stale", {bus.rsp_valid_o, bus.sqrt_start_valid_o}, '0);

        // Randomized traffic across many pointer wraps
        pushed = 0; got = 0; cyc = 0; m_busy = 0; m_cnt = 0; m_op = '0;
        while (got < 1000 && cyc < 50000) begin
            cyc++;
            if (!bus.req_valid_i && pushed < 1000 && $urandom_range(1, 0) == 1) begin
                bus.req_valid_i       = 1;
                bus.req_op_i          = {$urandom, $urandom};
                bus.req_tag_i         = pushed[3:0];
                bus.req_fp_format_i   = 2'($urandom_range(2, 0));
                bus.req_rm_i          = 3'($urandom_range(4, 0));
                bus.req_vector_mode_i = 1'($urandom_range(1, 0));
            end
            bus.sqrt_start_ready_i = ($urandom_range(3, 0) != 0);
            bus.rsp_ready_i        = ($urandom_range(1, 0) == 1);
            if (m_busy && m_cnt > 0) m_cnt--;
            bus.sqrt_finish_valid_i = m_busy && (m_cnt == 0);
            bus.sqrt_res_i          = model_res(m_op);
            bus.sqrt_fflags_i       = model_flags(m_op);
            #1;
            req_hs   = bus.req_valid_i & bus.req_ready_o;
            start_hs = bus.sqrt_start_valid_o & bus.sqrt_start_ready_i;
            fin_hs   = bus.sqrt_finish_valid_i & bus.sqrt_finish_ready_o;
            rsp_hs   = bus.rsp_valid_o & bus.rsp_ready_i;
            if (req_hs) begin
                exp_q.push_back({model_res(bus.req_op_i), model_flags(bus.req_op_i),
                                 bus.req_tag_i});
                pushed++;
            end
            if (rsp_hs) begin
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("rand_rsp", {bus.rsp_res_o, bus.rsp_fflags_o, bus.rsp_tag_o}, e);
                got++;
            end
            if (fin_hs) m_busy = 0;
            if (start_hs) begin
                m_busy = 1;
                m_cnt  = $urandom_range(6, 0);
                m_op   = bus.sqrt_op_o;
            end
            tick();
            if (req_hs) bus.req_valid_i = 0;
        end
        bus.req_valid_i = 0; bus.sqrt_start_ready_i = 0; bus.sqrt_finish_valid_i = 0;
        bus.rsp_ready_i = 0;
        chk("rand_done", {32'(got), 32'(pushed), 32'(exp_q.size())}, {32'd1000, 32'd1000, 32'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
